// File: rtl/imem_loader.sv
// Boot-time imem loader: parses a count/data/checksum byte stream into 32-bit
// little-endian words, writes them from index 0 and releases the CPU on a clean load.
module imem_loader #(
   parameter int IMEM_DEPTH      = 1024,
   parameter int IMEM_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [7:0]                 in_byte,
   output logic                       imem_we,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
   output logic [31:0]                imem_wdata,
   output logic                       cpu_reset_b,
   output logic                       done,
   output logic                       error
);

   typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR} state_t;

   localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);

   state_t      state;
   logic [15:0] count;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [7:0]  sum;
   logic [23:0] asm_lo;
   logic        ready_q;
   logic        accept;
   logic [15:0] hdr_n;
   logic        hdr_bad;

   // ready_q is the registered state-based ready; reset masks it in the same cycle
   assign in_ready = ready_q & ~reset;
   assign accept   = in_valid & in_ready;
   assign hdr_n    = {in_byte, count[7:0]};
   assign hdr_bad  = (hdr_n == 16'd0) || ({1'b0, hdr_n} > DEPTH_L);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= HDR_LO;
         count       <= '0;
         word_idx    <= '0;
         byte_idx    <= '0;
         sum         <= '0;
         asm_lo      <= '0;
         ready_q     <= 1'b1;
         imem_we     <= 1'b0;
         imem_waddr  <= '0;
         imem_wdata  <= '0;
         cpu_reset_b <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (accept) begin
            unique case (state)
               HDR_LO: begin
                  count[7:0] <= in_byte;
                  state      <= HDR_HI;
               end
               HDR_HI: begin
                  count[15:8] <= in_byte;
                  byte_idx    <= '0;
                  word_idx    <= '0;
                  sum         <= '0;
                  if (hdr_bad) begin
                     state   <= ERROR;
                     error   <= 1'b1;
                     ready_q <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  sum      <= sum + in_byte;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_lo[7:0]   <= in_byte;
                     2'd1: asm_lo[15:8]  <= in_byte;
                     2'd2: asm_lo[23:16] <= in_byte;
                     default: begin
                        // top byte goes straight to the write port, no extra stage
                        imem_we    <= 1'b1;
                        imem_waddr <= word_idx[IMEM_ADDR_WIDTH-1:0];
                        imem_wdata <= {in_byte, asm_lo};
                        word_idx   <= word_idx + 16'd1;
                        if (word_idx == count - 16'd1) state <= CSUM;
                     end
                  endcase
               end
               CSUM: begin
                  ready_q <= 1'b0;
                  if (in_byte == sum) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     cpu_reset_b <= 1'b1;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios, write scoreboard,
// plus a hand-written reset-mid-load sequence.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_byte = 8'h00;
   logic        imem_we;
   logic [9:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_reset_b;
   logic        done;
   logic        error;

   imem_loader #(.IMEM_DEPTH(1024), .IMEM_ADDR_WIDTH(10)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_byte(in_byte), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .cpu_reset_b(cpu_reset_b), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] n;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [7:0]  csum_off;
      bit          exp_done;
      bit          bubbles;
   } vec_t;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every write pulse must match the next expected write
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_write: got addr=%0d data=%h expected no write", imem_waddr, imem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (imem_waddr !== e.addr || imem_wdata !== e.data) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                        imem_waddr, imem_wdata, e.addr, e.data);
            end
         end
      end
   end

   function automatic logic [31:0] wgen(input int idx, input logic [31:0] w0, input logic [31:0] w1);
      if (idx == 0) return w0;
      if (idx == 1) return w1;
      return 32'(idx) * 32'h9E37_79B1;
   endfunction

   task automatic send(input logic [7:0] b, input bit bub);
      bit ok = 1'b0;
      bit now;
      for (int t = 0; t < 64 && !ok; t++) begin
         @(negedge clk);
         now = 1'b0;
         if (bub && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_byte  = b;
            now      = in_ready;
         end
         @(posedge clk);
         ok = now;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %h never accepted, expected acceptance", b);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_we",    32'(imem_we),     32'd0);
      chk("rst_waddr", 32'(imem_waddr),  32'd0);
      chk("rst_wdata", imem_wdata,       32'd0);
      chk("rst_done",  32'(done),        32'd0);
      chk("rst_error", 32'(error),       32'd0);
      chk("rst_cpurb", 32'(cpu_reset_b), 32'd0);
      chk("rst_ready", 32'(in_ready),    32'd0);
      reset = 1'b0;
   endtask

   task automatic run_load(input vec_t v);
      logic [7:0]  s;
      logic [31:0] w;
      reset_dut();
      send(v.n[7:0], v.bubbles);
      send(v.n[15:8], v.bubbles);
      if (v.n != 16'd0 && v.n <= 16'd1024) begin
         s = 8'd0;
         for (int i = 0; i < int'(v.n); i++) begin
            w = wgen(i, v.w0, v.w1);
            exp_q.push_back('{addr: 10'(i), data: w});
            for (int b = 0; b < 4; b++) begin
               s = s + w[8*b +: 8];
               send(w[8*b +: 8], v.bubbles);
            end
         end
         send(s + v.csum_off, v.bubbles);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk({v.name, "_done"},  32'(done),        32'(v.exp_done));
      chk({v.name, "_error"}, 32'(error),       32'(!v.exp_done));
      chk({v.name, "_cpurb"}, 32'(cpu_reset_b), 32'(v.exp_done));
      chk({v.name, "_ready"}, 32'(in_ready),    32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_byte  = 8'h55;
         chk({v.name, "_late_ready"}, 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk({v.name, "_done_hold"}, 32'(done), 32'(v.exp_done));
      chk({v.name, "_pending"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{"nominal",  16'd2,    32'h0050_0093, 32'h00A0_0113, 8'd0, 1'b1, 1'b0};
      vecs[1] = '{"bad_csum", 16'd2,    32'h0050_0093, 32'h00A0_0113, 8'd1, 1'b0, 1'b0};
      vecs[2] = '{"n_zero",   16'd0,    32'h0,         32'h0,         8'd0, 1'b0, 1'b0};
      vecs[3] = '{"n_1025",   16'd1025, 32'h0,         32'h0,         8'd0, 1'b0, 1'b0};
      vecs[4] = '{"n_1024",   16'd1024, 32'h1234_5678, 32'hCAFE_F00D, 8'd0, 1'b1, 1'b0};
      vecs[5] = '{"bubbles",  16'd2,    32'h0050_0093, 32'h00A0_0113, 8'd0, 1'b1, 1'b1};
      vecs[6] = '{"one_word", 16'd1,    32'hDEAD_BEEF, 32'h0,         8'd0, 1'b1, 1'b1};

      for (int i = 0; i < 7; i++) run_load(vecs[i]);

      // Reset after 5 data bytes: only the first complete word may be written
      reset_dut();
      exp_q.push_back('{addr: 10'd0, data: 32'h0050_0093});
      send(8'h02, 1'b0); send(8'h00, 1'b0);
      send(8'h93, 1'b0); send(8'h00, 1'b0); send(8'h50, 1'b0); send(8'h00, 1'b0);
      send(8'h13, 1'b0);
      reset_dut();
      chk("midrst_pending", 32'(exp_q.size()), 32'd0);
      run_load(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
